// File: rtl/ec_pkg.sv
// Shared types for the G1 affine point sequencer: widths, point struct,
// FSM state encoding, infinity encoding and the point comparator.
package ec_pkg;

    localparam int P_WIDTH = 377;
    localparam int K_WIDTH = 253;
    localparam int IDX_W   = $clog2(K_WIDTH);

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } affine_point_t;

    // The point at infinity is carried as all-zero coordinates plus a flag.
    localparam affine_point_t PT_INF = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DBL_ISSUE,
        S_DBL_WAIT,
        S_BIT,
        S_ADD_ISSUE,
        S_ADD_WAIT,
        S_DONE
    } ec_state_t;

    // What a finished doubling is used for.
    typedef enum logic [1:0] {
        DU_SCAN,   // acc <- 2*acc, then handle the current bit
        DU_BIT,    // acc == P on a set bit: acc <- 2*P, then next bit
        DU_PRE     // precompute 2*P for the constant-time dummy path
    } dbl_use_t;

    typedef enum logic [1:0] {
        REL_OTHER,
        REL_EQUAL,
        REL_NEG
    } pt_rel_t;

    // Same x with different y means b == -a on the curve.
    function automatic pt_rel_t pt_compare(input affine_point_t a, input affine_point_t b);
        if (a.x != b.x) return REL_OTHER;
        if (a.y == b.y) return REL_EQUAL;
        return REL_NEG;
    endfunction

endpackage

// File: rtl/point_scalar_mul.sv
// R = k*P by left-to-right double-and-add, driving point_double/point_add.
// Build option POINT_SCALAR_MUL_CONST_TIME_EN: every bit issues one double
// and one add-path operation; unused results are discarded by mux.
//
// Engine handshake: the sequencer drives operands and holds <eng>_Reset
// high for exactly one cycle; operands stay stable until the engine raises
// <eng>_Done, and only the first Done-high cycle in WAIT is captured.
module point_scalar_mul
    import ec_pkg::*;
(
    input  logic                 clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [K_WIDTH-1:0]   k,
    input  logic [2*P_WIDTH-1:0] P,
    output logic                 busy,
    output logic                 done,
    output logic [2*P_WIDTH-1:0] R,
    output logic                 R_inf,
    output logic                 dbl_Reset,
    output logic [2*P_WIDTH-1:0] dbl_P,
    input  logic                 dbl_Done,
    input  logic [2*P_WIDTH-1:0] dbl_R,
    output logic                 add_Reset,
    output logic [2*P_WIDTH-1:0] add_P,
    output logic [2*P_WIDTH-1:0] add_Q,
    input  logic                 add_Done,
    input  logic [2*P_WIDTH-1:0] add_R,
    output ec_state_t            dbg_state
);

    ec_state_t          state, state_n;
    dbl_use_t           dbl_use, dbl_use_n;
    affine_point_t      p_q, p_n, acc, acc_n, r_q, r_n;
    logic               acc_inf, acc_inf_n, r_inf_q, r_inf_n;
    logic [K_WIDTH-1:0] k_q, k_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               bit_set, last_bit, step;
    pt_rel_t            rel;
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
    affine_point_t      p2_q, p2_n;
    logic               add_real;
`endif

    assign bit_set  = k_q[idx];
    assign last_bit = (idx == '0);
    assign rel      = pt_compare(acc, p_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_IDLE;
            dbl_use <= DU_SCAN;
            p_q     <= PT_INF;
            acc     <= PT_INF;
            acc_inf <= 1'b1;
            r_q     <= PT_INF;
            r_inf_q <= 1'b1;
            k_q     <= '0;
            idx     <= '0;
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
            p2_q    <= PT_INF;
`endif
        end else begin
            state   <= state_n;
            dbl_use <= dbl_use_n;
            p_q     <= p_n;
            acc     <= acc_n;
            acc_inf <= acc_inf_n;
            r_q     <= r_n;
            r_inf_q <= r_inf_n;
            k_q     <= k_n;
            idx     <= idx_n;
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
            p2_q    <= p2_n;
`endif
        end
    end

    // Next-state and accumulator update; 'step' moves on to the next bit
    always_comb begin
        state_n   = state;
        dbl_use_n = dbl_use;
        p_n       = p_q;
        acc_n     = acc;
        acc_inf_n = acc_inf;
        r_n       = r_q;
        r_inf_n   = r_inf_q;
        k_n       = k_q;
        idx_n     = idx;
        step      = 1'b0;
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
        p2_n      = p2_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    k_n       = k;
                    p_n       = affine_point_t'(P);
                    acc_n     = PT_INF;
                    acc_inf_n = 1'b1;
                    idx_n     = IDX_W'(K_WIDTH - 1);
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
                    dbl_use_n = DU_PRE;
                    state_n   = S_DBL_ISSUE;
`else
                    state_n   = S_SCAN;
`endif
                end
            end
            S_SCAN: begin
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
                dbl_use_n = DU_SCAN;
                state_n   = S_DBL_ISSUE;
`else
                if (!acc_inf) begin
                    dbl_use_n = DU_SCAN;
                    state_n   = S_DBL_ISSUE;
                end else begin
                    // Doubling infinity is a no-op; a set bit just loads P.
                    if (bit_set) begin
                        acc_n     = p_q;
                        acc_inf_n = 1'b0;
                    end
                    step = 1'b1;
                end
`endif
            end
            S_DBL_ISSUE: state_n = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (dbl_Done) begin
                    case (dbl_use)
                        DU_SCAN: begin
                            if (!acc_inf) acc_n = affine_point_t'(dbl_R);
                            state_n = S_BIT;
                        end
                        DU_BIT: begin
                            acc_n = affine_point_t'(dbl_R);
                            step  = 1'b1;
                        end
                        DU_PRE: begin
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
                            p2_n = affine_point_t'(dbl_R);
`endif
                            state_n = S_SCAN;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
            S_BIT: begin
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
                state_n = S_ADD_ISSUE;
`else
                if (!bit_set) begin
                    step = 1'b1;
                end else begin
                    case (rel)
                        REL_EQUAL: begin
                            // The adder cannot take equal points.
                            dbl_use_n = DU_BIT;
                            state_n   = S_DBL_ISSUE;
                        end
                        REL_NEG: begin
                            acc_n     = PT_INF;
                            acc_inf_n = 1'b1;
                            step      = 1'b1;
                        end
                        default: state_n = S_ADD_ISSUE;
                    endcase
                end
`endif
            end
            S_ADD_ISSUE: state_n = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (add_Done) begin
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
                    if (bit_set) begin
                        if (acc_inf) begin
                            acc_n     = p_q;
                            acc_inf_n = 1'b0;
                        end else begin
                            case (rel)
                                REL_EQUAL: acc_n = p2_q;
                                REL_NEG: begin
                                    acc_n     = PT_INF;
                                    acc_inf_n = 1'b1;
                                end
                                default:   acc_n = affine_point_t'(add_R);
                            endcase
                        end
                    end
`else
                    acc_n = affine_point_t'(add_R);
`endif
                    step = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (step) begin
            if (last_bit) begin
                r_n     = acc_inf_n ? PT_INF : acc_n;
                r_inf_n = acc_inf_n;
                state_n = S_DONE;
            end else begin
                idx_n   = idx - 1'b1;
                state_n = S_SCAN;
            end
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign R         = r_q;
    assign R_inf     = r_inf_q;
    assign dbl_Reset = (state == S_DBL_ISSUE);
    assign add_Reset = (state == S_ADD_ISSUE);
    // Infinity is only doubled as a discarded dummy; P is a safe operand.
    assign dbl_P     = acc_inf ? p_q : acc;
    assign add_Q     = p_q;
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
    // Dummy adds use 2P + P so the adder never sees equal/opposite points.
    assign add_real  = !acc_inf && (rel == REL_OTHER);
    assign add_P     = add_real ? acc : p2_q;
`else
    assign add_P     = acc;
`endif
    assign dbg_state = state;

endmodule

// File: tb/tb_point_scalar_mul.sv
// Bench for point_scalar_mul. Engines are stubbed over a toy cyclic group of
// prime order N: point n*G is encoded as {x = min(n, N-n), y = n}, so equal
// and opposite points behave as on a real curve. The reference result is
// simply (k*m mod N)*G for P = m*G.
`timescale 1ns/1ps
module tb_point_scalar_mul;
    import ec_pkg::*;

    localparam int W  = 2*P_WIDTH;
    localparam int WR = W + 1;
    localparam int N  = 13;

    logic               clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               start = 1'b0;
    logic [K_WIDTH-1:0] k = '0;
    logic [W-1:0]       P = '0;
    logic               busy, done, R_inf, dbl_Reset, add_Reset;
    logic [W-1:0]       R, dbl_P, add_P, add_Q;
    logic               dbl_Done = 1'b0, add_Done = 1'b0;
    logic [W-1:0]       dbl_R = '0, add_R = '0;
    ec_state_t          dbg_state;

    point_scalar_mul dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .k(k), .P(P),
        .busy(busy), .done(done), .R(R), .R_inf(R_inf),
        .dbl_Reset(dbl_Reset), .dbl_P(dbl_P), .dbl_Done(dbl_Done), .dbl_R(dbl_R),
        .add_Reset(add_Reset), .add_P(add_P), .add_Q(add_Q),
        .add_Done(add_Done), .add_R(add_R), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [WR-1:0] act, input logic [WR-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- toy group model ----------------
    function automatic logic [W-1:0] enc(input int n);
        logic [P_WIDTH-1:0] x, y;
        x = P_WIDTH'((n < N - n) ? n : N - n);
        y = P_WIDTH'(n);
        return {x, y};
    endfunction

    function automatic int dec(input logic [W-1:0] pt);
        return int'(pt[31:0]);
    endfunction

    function automatic logic valid_pt(input logic [W-1:0] pt);
        int n;
        n = dec(pt);
        return (n > 0) && (n < N) && (pt == enc(n));
    endfunction

    function automatic logic [WR-1:0] model_out(input logic [K_WIDTH-1:0] kk, input int m);
        logic [K_WIDTH-1:0] kr;
        int n;
        kr = kk % K_WIDTH'(N);
        n  = (int'(kr[7:0]) * m) % N;
        if (n == 0) return {1'b1, W'(0)};
        return {1'b0, enc(n)};
    endfunction

    // ---------------- engine stubs ----------------
    int lat_lo = 5, lat_hi = 5;
    int dbl_cnt = 0, add_cnt = 0, dbl_calls = 0, add_calls = 0;
    logic [W-1:0] dbl_last = '0, add_last_p = '0, add_last_q = '0;

    always @(posedge clk) begin
        #1;
        if (dbl_Reset) begin
            dbl_calls++;
            dbl_last = dbl_P;
            dbl_cnt  = int'($urandom_range(lat_hi, lat_lo));
            dbl_Done = 1'b0;
            chk("dbl_operand_valid", WR'(valid_pt(dbl_P)), WR'(1));
        end else if (dbl_cnt > 0) begin
            if (dbg_state == S_DBL_WAIT) chk("dbl_hold", WR'(dbl_P), WR'(dbl_last));
            dbl_cnt--;
            if (dbl_cnt == 0) begin
                dbl_Done = 1'b1;
                dbl_R    = enc((2 * dec(dbl_last)) % N);
            end
        end else begin
            dbl_Done = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (add_Reset) begin
            add_calls++;
            add_last_p = add_P;
            add_last_q = add_Q;
            add_cnt    = int'($urandom_range(lat_hi, lat_lo));
            add_Done   = 1'b0;
            chk("add_operands_valid", WR'(valid_pt(add_P) && valid_pt(add_Q)), WR'(1));
            chk("add_distinct", WR'((dec(add_P) != dec(add_Q)) && (dec(add_P) + dec(add_Q) != N)), WR'(1));
        end else if (add_cnt > 0) begin
            if (dbg_state == S_ADD_WAIT) chk("add_hold", WR'({add_P, add_Q} == {add_last_p, add_last_q}), WR'(1));
            add_cnt--;
            if (add_cnt == 0) begin
                add_Done = 1'b1;
                add_R    = enc((dec(add_last_p) + dec(add_last_q)) % N);
            end
        end else begin
            add_Done = 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [WR-1:0] exp_q[$];
    int done_cnt = 0, done_cyc = 0, start_cyc = 0;

    always @(negedge clk) begin
        if (Reset_n && done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending run");
            end else begin
                chk("result", {R_inf, R}, exp_q.pop_front());
            end
            chk("done_busy", WR'(busy), WR'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [K_WIDTH-1:0] kk, input int m);
        @(posedge clk); #1;
        k         = kk;
        P         = enc(m);
        start     = 1'b1;
        start_cyc = cyc;
        exp_q.push_back(model_out(kk, m));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", WR'(busy), WR'(1));
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 40000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done in %0d cycles required done", n);
        end
    endtask

    task automatic run(input logic [K_WIDTH-1:0] kk, input int m);
        int d0;
        d0 = done_cnt;
        start_run(kk, m);
        wait_done(d0);
    endtask

    task automatic clear_counts();
        dbl_calls = 0;
        add_calls = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int m, d0, n;
        logic [K_WIDTH-1:0] kk;
`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
        int d1, a1, l1;
`endif

        // Reset held with start asserted: nothing may start or pulse.
        Reset_n = 1'b0;
        start   = 1'b1;
        k       = '1;
        P       = enc(3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_R", {R_inf, R}, {1'b1, W'(0)});
        chk("rst_ctrl", WR'({busy, done, dbl_Reset, add_Reset}), WR'(0));
        start   = 1'b0;
        Reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ctrl", WR'({busy, done}), WR'(0));
        chk("post_rst_R", {R_inf, R}, {1'b1, W'(0)});
        chk("rst_no_engine", WR'(dbl_calls + add_calls), WR'(0));

        // Hand-computed pins for the model itself.
        chk("pin_enc5", WR'(enc(5)), {1'b0, P_WIDTH'(5), P_WIDTH'(5)});
        chk("pin_enc11", WR'(enc(11)), {1'b0, P_WIDTH'(2), P_WIDTH'(11)});
        chk("pin_model_7x4", model_out(K_WIDTH'(7), 4), {1'b0, P_WIDTH'(2), P_WIDTH'(2)});
        chk("pin_model_13x5", model_out(K_WIDTH'(13), 5), {1'b1, W'(0)});

        // k = 0 on the generator.
        lat_lo = 5; lat_hi = 5;
        clear_counts();
        run('0, 1);
`ifndef POINT_SCALAR_MUL_CONST_TIME_EN
        chk("k0_latency", WR'(done_cyc - start_cyc + 1), WR'(K_WIDTH + 2));
        chk("k0_no_engine", WR'(dbl_calls + add_calls), WR'(0));
`endif

        // k = 1 -> R = P.
        m = int'($urandom_range(12, 1));
        clear_counts();
        run(K_WIDTH'(1), m);
        chk("k1_R_eq_P", {R_inf, R}, {1'b0, P});
`ifndef POINT_SCALAR_MUL_CONST_TIME_EN
        chk("k1_no_engine", WR'(dbl_calls + add_calls), WR'(0));
`endif

        // k = 2 -> one doubling of P.
        m = int'($urandom_range(12, 1));
        clear_counts();
        run(K_WIDTH'(2), m);
`ifndef POINT_SCALAR_MUL_CONST_TIME_EN
        chk("k2_dbl_calls", WR'(dbl_calls), WR'(1));
        chk("k2_add_calls", WR'(add_calls), WR'(0));
        chk("k2_dbl_P", WR'(dbl_last), WR'(enc(m)));
`endif

        // k = 3 with a second start pulse while busy.
        m = int'($urandom_range(12, 1));
        clear_counts();
        d0 = done_cnt;
        start_run(K_WIDTH'(3), m);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        k     = K_WIDTH'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (300) @(posedge clk);
        chk("k3_single_done", WR'(done_cnt), WR'(d0 + 1));
`ifndef POINT_SCALAR_MUL_CONST_TIME_EN
        chk("k3_calls", WR'({dbl_calls[7:0], add_calls[7:0]}), WR'({8'd1, 8'd1}));
        chk("k3_add_P", WR'(add_last_p), WR'(enc((2 * m) % N)));
        chk("k3_add_Q", WR'(add_last_q), WR'(enc(m)));
`endif

        // Negation (k = 13) and equal-point (k = 15) paths.
        lat_lo = 1; lat_hi = 4;
        run(K_WIDTH'(13), int'($urandom_range(12, 1)));
        run(K_WIDTH'(15), 1);
        run(K_WIDTH'(15), int'($urandom_range(12, 1)));

        // Reset mid ADD_WAIT on k = 5, then k = 7.
        lat_lo = 1; lat_hi = 37;
        m  = int'($urandom_range(12, 1));
        d0 = done_cnt;
        start_run(K_WIDTH'(5), m);
        n = 0;
        while (dbg_state != S_ADD_WAIT && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_add_wait", WR'(dbg_state == S_ADD_WAIT), WR'(1));
        #2;
        Reset_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_R", {R_inf, R}, {1'b1, W'(0)});
        chk("midrst_ctrl", WR'({busy, done, dbl_Reset, add_Reset}), WR'(0));
        Reset_n = 1'b1;
        chk("abort_silent", WR'(done_cnt), WR'(d0));
        run(K_WIDTH'(7), m);

        // Randomized scalars, with random-length leading-zero runs.
        lat_lo = 1; lat_hi = 4;
        for (int t = 0; t < 10; t++) begin
            for (int w = 0; w < 8; w++) kk[w*32 +: 29] = 29'($urandom);
            for (int w = 0; w < 8; w++) kk[w*32 + 29 +: 3] = 3'($urandom);
            kk = kk >> $urandom_range(252, 0);
            run(kk, int'($urandom_range(12, 1)));
        end

`ifdef POINT_SCALAR_MUL_CONST_TIME_EN
        // Dispatch and timing must not depend on k.
        lat_lo = 3; lat_hi = 3;
        m = int'($urandom_range(12, 1));
        clear_counts();
        run(K_WIDTH'(1), m);
        d1 = dbl_calls;
        a1 = add_calls;
        l1 = done_cyc - start_cyc;
        chk("ct_dbl_count", WR'(d1), WR'(K_WIDTH + 1));
        chk("ct_add_count", WR'(a1), WR'(K_WIDTH));
        kk = '0;
        kk[K_WIDTH-1] = 1'b1;
        clear_counts();
        run(kk, m);
        chk("ct_same_dbl", WR'(dbl_calls), WR'(d1));
        chk("ct_same_add", WR'(add_calls), WR'(a1));
        chk("ct_same_latency", WR'(done_cyc - start_cyc), WR'(l1));
`endif

        repeat (5) @(posedge clk);
        chk("queue_empty", WR'(exp_q.size()), WR'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/point_scalar_mul.md
Name: point_scalar_mul

Overview:
- Scalar-multiplication sequencer for BLS12-377 G1 affine points: computes R = k·P by left-to-right double-and-add.
- Acts as the initiator for the existing point-operation responders (point_double, point_add), which run a Reset-to-start / Done-when-finished handshake.
- Drives operands and start pulses to those engines and captures their results.
- Sits between the MSM bucket logic and the point arithmetic units.

Parameters:
- P_WIDTH, 377, coordinate width in bits.
- K_WIDTH, 253, scalar width in bits.

Ports:
- clk  in  1  clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k  in  K_WIDTH  scalar; latched on accepted start.
- P  in  2*P_WIDTH  base point {x,y}; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when R is valid.
- R  out  2*P_WIDTH  result {x,y}; held until the next accepted start.
- R_inf  out  1  result is the point at infinity (R is all-zero when set).
- dbl_Reset  out  1  start pulse to the doubling engine.
- dbl_P  out  2*P_WIDTH  doubling operand.
- dbl_Done  in  1  doubling engine finished.
- dbl_R  in  2*P_WIDTH  doubling result.
- add_Reset  out  1  start pulse to the adder.
- add_P  out  2*P_WIDTH  adder operand 1 (accumulator).
- add_Q  out  2*P_WIDTH  adder operand 2 (base point).
- add_Done  in  1  adder finished.
- add_R  in  2*P_WIDTH  adder result.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. busy, done, dbl_Reset and add_Reset are 0. R = 0, R_inf = 1, accumulator cleared.
- Reset mid-operation: all engine requests are dropped. Engine outputs are ignored until the next issued request.
- State IDLE: on start=1, latch k and P, set acc_inf=1, bit index = K_WIDTH-1, go to SCAN. start in any other state is ignored.
- State SCAN, per bit i from MSB down:
  - If acc_inf=0, go to DBL_ISSUE.
  - Otherwise skip doubling; leading zeros cost 1 cycle each.
  - Then go to bit handling.
- Issue protocol (DBL_ISSUE/ADD_ISSUE):
  - Operands are driven and the engine Reset is held high for exactly 1 cycle.
  - Then go to the corresponding WAIT state.
  - Operands are held stable throughout WAIT.
- WAIT: on the first cycle Done=1, capture the engine R into acc. No capture before that.
- Bit handling when k[i]=1:
  - acc_inf=1: acc ← P, acc_inf ← 0. No engine call, 1 cycle.
  - acc == P: issue a double instead of an add, since the adder cannot take equal points.
  - acc.x == P.x and acc.y != P.y: acc_inf ← 1, no engine call.
  - Otherwise: issue an add with add_P = acc, add_Q = P.
- Bit handling when k[i]=0: nothing.
- After bit 0: go to DONE.
- State DONE: R ← acc (or 0), R_inf ← acc_inf, done = 1 for 1 cycle, busy = 0, return to IDLE.
- Boundary results: k=0 gives R_inf=1 with no engine calls. k=1 gives R=P with no engine calls.
- Latency: depends on the data and the engines. No timeout.

Optional Feature:
- Macro: POINT_SCALAR_MUL_CONST_TIME_EN.
- When defined:
  - Every bit issues a double and an add-path operation regardless of k[i] and acc_inf.
  - Dummy results are discarded by mux; acc is updated only when it would be in normal mode.
  - The dispatch sequence and total cycle count are independent of k for fixed engine latency.
- When undefined: behaviour is as described above (variable time).

Decomposition:
- Package ec_pkg holds:
  - P_WIDTH and K_WIDTH.
  - typedef affine_point_t {x, y}.
  - The FSM state enum.
  - The infinity encoding constant.
- No sub-module. The equality/negation comparator is a function in ec_pkg.

Test Plan:
- Reset with start asserted, releasing Reset_n -> R_inf=1, R=0, busy=0, done=0; no engine Reset pulses.
- k=0, P=generator -> done after K_WIDTH+2 cycles; R_inf=1; zero dbl/add requests.
- k=1 -> R=P, R_inf=0; zero engine requests.
- k=2 -> exactly one dbl_Reset with dbl_P=P. Stub latency 5; R equals the golden-model 2P.
- k=3 -> one double, then one add with add_P=2P and add_Q=P; R equals the golden 3P.
  - Second start pulse during busy is ignored.
- k=5, engine stub latency 1/37 randomized; Reset_n dropped mid-ADD_WAIT, then k=7 -> first run aborted silently; second R equals the golden 7P.
- CONST_TIME_EN run on k=1 and k=2^252 -> identical dispatch counts and identical done cycle.
